usb_rw_xact_ctrl: RTL
=====================

// Module: usb_rw_xact_ctrl
// PURPOSE
//  Parametrised read/write sequencer above the OUT/IN transaction engines of the USB host.
//  - Read: OUT(addr packet, ADDR_ENDP), then IN(data). Write: OUT(addr packet, ADDR_ENDP), then OUT(write data, DATA_ENDP).
//  - Adds per-phase retry, a done-watchdog, explicit failure reporting and a busy flag.
// PARAMETERS
//  DATA_W      64   payload width; must satisfy DATA_W >= ADDR_W
//  ADDR_W      16   memory page width
//  ADDR_ENDP   4    endpoint used for address OUT transactions
//  DATA_ENDP   8    endpoint used for write-data OUT transactions
//  MAX_RETRY   3    re-issues allowed per phase after the first attempt (0 = no retry)
//  TIMEOUT_CYC 4096 cycles allowed from engine start to engine done
// PORTS
//  clock          in   1        clock
//  reset_n        in   1        asynchronous, active-low reset
//  read_start     in   1        pulse; request a page read
//  write_start    in   1        pulse; request a page write
//  mempage        in   ADDR_W   target page; captured on accepted start
//  write_data     in   DATA_W   write payload; captured on accepted start
//  busy           out  1        high from accept until the done pulse
//  read_success   out  1        1-cycle pulse; read completed
//  write_success  out  1        1-cycle pulse; write completed
//  failure        out  1        1-cycle pulse; operation aborted
//  read_data      out  DATA_W   last successfully read payload
//  out_start      out  1        1-cycle pulse to the OUT engine
//  out_endp       out  4        endpoint for the OUT engine; held while busy
//  out_data       out  DATA_W   payload for the OUT engine; held while busy
//  out_done       in   1        OUT engine finished
//  out_success    in   1        qualifies out_done
//  in_start       out  1        1-cycle pulse to the IN engine
//  in_done        in   1        IN engine finished
//  in_success     in   1        qualifies in_done
//  in_data        in   DATA_W   valid when in_done && in_success
// BEHAVIOUR
//  - All outputs are registered. Reset (async) sets: state IDLE; all outputs 0; read_data 0; counters 0.
//  - Reset mid-operation aborts the operation silently. No failure pulse is generated.
//  - IDLE: a start is accepted at edge t. Then busy=1 and the first engine start pulse appear at t+1.
//    - If read_start and write_start are high together, read wins; the write is dropped.
//    - Starts arriving while busy are ignored and not queued.
//  - Address packet = {mempage, (DATA_W-ADDR_W)'0}, i.e. page in the MSBs, zero-padded.
//  - States: IDLE -> RD_ADDR -> RD_DATA -> IDLE; IDLE -> WR_ADDR -> WR_DATA -> IDLE.
//    - RD_ADDR / WR_ADDR use out_endp=ADDR_ENDP, out_data=addr packet.
//    - WR_DATA uses out_endp=DATA_ENDP, out_data=captured write_data. RD_DATA uses in_start.
//  - Phase end: the first cycle the relevant done is high (out_done or in_done).
//    - success=1: on the next edge, start the next phase (start pulse the cycle after), or finish.
//    - success=0 or timeout: if attempt count < MAX_RETRY, increment it and re-pulse the same phase's start next cycle.
//      Otherwise abort: failure pulse, busy drops the same cycle, return to IDLE.
//  - Attempt counter clears on each phase entry. Earlier phases are never repeated.
//  - Watchdog: counts cycles from the start pulse. Timeout fires when the count reaches TIMEOUT_CYC with no done.
//    - A done arriving in the same cycle as the timeout wins; the timeout is ignored.
//    - Done while the FSM is not waiting is ignored.
//  - Finish: the success pulse and busy=0 occur in the cycle after the final done.
//    - On a read finish, read_data is loaded from in_data in that same cycle; otherwise read_data holds.
//  - Min read/write latency = 1 + engine latencies + 2 cycles of hand-off.
// CONFIGURATION
//  RW_READBACK_VERIFY_EN defined:
//    - After WR_DATA succeeds, run VF_ADDR (OUT addr) -> VF_DATA (IN); both have retry/timeout.
//    - in_data == captured write_data -> write_success; mismatch -> failure.
//    - read_data is not updated by the verify read.
//  Undefined: the VF_ states are absent; write_success follows WR_DATA success directly.
// TESTING
//  - Read, all ok: page 0x1234, engines done+success after 5 cycles, in_data=64'hDEAD_BEEF_0000_0001 -> out_data=64'h1234_0000_0000_0000, endp 4; one read_success; read_data = that value.
//  - Write, all ok: page 0x00FF, data 64'hA5A5... -> OUT endp4 with 64'h00FF_0000_0000_0000, then OUT endp8 with 64'hA5A5...; one write_success.
//  - Retry: MAX_RETRY=3, WR_DATA fails twice then succeeds -> 3 data out_start pulses, 1 address pulse, write_success, no failure.
//  - Exhaust/timeout: TIMEOUT_CYC=16, out_done never comes -> 4 out_start pulses spaced by 16+ cycles, then failure; busy=0; read_data unchanged.
//  - Collisions: read_start and write_start high together -> read flow only; write_start while busy -> ignored; reset_n low mid-RD_DATA -> all outputs 0, IDLE.
//  - With RW_READBACK_VERIFY_EN: verify in_data differs in bit 0 -> failure, no write_success.

Source files
------------

// File: rtl/usb_rw_xact_ctrl.sv
// Page read/write sequencer over the USB OUT/IN transaction engines, with per-phase retry and a done-watchdog.
// Optional readback verify of writes (VF_ADDR/VF_DATA) when RW_READBACK_VERIFY_EN is defined.
module usb_rw_xact_ctrl #(
  parameter int DATA_W      = 64,
  parameter int ADDR_W      = 16,
  parameter int ADDR_ENDP   = 4,
  parameter int DATA_ENDP   = 8,
  parameter int MAX_RETRY   = 3,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              read_start,
  input  logic              write_start,
  input  logic [ADDR_W-1:0] mempage,
  input  logic [DATA_W-1:0] write_data,
  output logic              busy,
  output logic              read_success,
  output logic              write_success,
  output logic              failure,
  output logic [DATA_W-1:0] read_data,
  output logic              out_start,
  output logic [3:0]        out_endp,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_done,
  input  logic              out_success,
  output logic              in_start,
  input  logic              in_done,
  input  logic              in_success,
  input  logic [DATA_W-1:0] in_data
);

  localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int ATT_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [3:0] ADDR_EP = 4'(ADDR_ENDP);
  localparam logic [3:0] DATA_EP = 4'(DATA_ENDP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR_ADDR,
    S_WR_DATA
`ifdef RW_READBACK_VERIFY_EN
    ,
    S_VF_ADDR,
    S_VF_DATA
`endif
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_page;
  logic [DATA_W-1:0] r_wdata;
  logic [WD_W-1:0]   r_wd;
  logic [ATT_W-1:0]  r_att;

  logic w_wait_out;
  logic w_wait_in;
  logic w_done;
  logic w_ok;
  logic w_timeout;
  logic w_can_retry;

  function automatic logic [DATA_W-1:0] addr_pkt(input logic [ADDR_W-1:0] page);
    return DATA_W'(page) << (DATA_W - ADDR_W);
  endfunction

  always_comb begin
    w_wait_out = 1'b0;
    w_wait_in  = 1'b0;
    case (r_state)
      S_RD_ADDR, S_WR_ADDR, S_WR_DATA: w_wait_out = 1'b1;
      S_RD_DATA:                       w_wait_in  = 1'b1;
`ifdef RW_READBACK_VERIFY_EN
      S_VF_ADDR:                       w_wait_out = 1'b1;
      S_VF_DATA:                       w_wait_in  = 1'b1;
`endif
      default: ;
    endcase
  end

  // A done in the same cycle as the watchdog expiry takes precedence over the timeout.
  assign w_done      = (w_wait_out & out_done) | (w_wait_in & in_done);
  assign w_ok        = (w_wait_out & out_success) | (w_wait_in & in_success);
  assign w_timeout   = (r_wd == WD_W'(TIMEOUT_CYC - 1));
  assign w_can_retry = (r_att < ATT_W'(MAX_RETRY));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_page        <= '0;
      r_wdata       <= '0;
      r_wd          <= '0;
      r_att         <= '0;
      busy          <= 1'b0;
      read_success  <= 1'b0;
      write_success <= 1'b0;
      failure       <= 1'b0;
      read_data     <= '0;
      out_start     <= 1'b0;
      out_endp      <= '0;
      out_data      <= '0;
      in_start      <= 1'b0;
    end else begin
      out_start     <= 1'b0;
      in_start      <= 1'b0;
      read_success  <= 1'b0;
      write_success <= 1'b0;
      failure       <= 1'b0;
      if (r_state == S_IDLE) begin
        if (read_start || write_start) begin
          r_state   <= read_start ? S_RD_ADDR : S_WR_ADDR;
          r_page    <= mempage;
          r_wdata   <= write_data;
          r_wd      <= '0;
          r_att     <= '0;
          busy      <= 1'b1;
          out_start <= 1'b1;
          out_endp  <= ADDR_EP;
          out_data  <= addr_pkt(mempage);
        end
      end else if (w_done && w_ok) begin
        r_wd  <= '0;
        r_att <= '0;
        case (r_state)
          S_RD_ADDR: begin
            r_state  <= S_RD_DATA;
            in_start <= 1'b1;
          end
          S_RD_DATA: begin
            r_state      <= S_IDLE;
            busy         <= 1'b0;
            read_success <= 1'b1;
            read_data    <= in_data;
          end
          S_WR_ADDR: begin
            r_state   <= S_WR_DATA;
            out_start <= 1'b1;
            out_endp  <= DATA_EP;
            out_data  <= r_wdata;
          end
`ifdef RW_READBACK_VERIFY_EN
          S_WR_DATA: begin
            r_state   <= S_VF_ADDR;
            out_start <= 1'b1;
            out_endp  <= ADDR_EP;
            out_data  <= addr_pkt(r_page);
          end
          S_VF_ADDR: begin
            r_state  <= S_VF_DATA;
            in_start <= 1'b1;
          end
          S_VF_DATA: begin
            r_state       <= S_IDLE;
            busy          <= 1'b0;
            write_success <= (in_data == r_wdata);
            failure       <= (in_data != r_wdata);
          end
`else
          S_WR_DATA: begin
            r_state       <= S_IDLE;
            busy          <= 1'b0;
            write_success <= 1'b1;
          end
`endif
          default: begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end else if (w_done || w_timeout) begin
        r_wd <= '0;
        if (w_can_retry) begin
          r_att     <= r_att + 1'b1;
          out_start <= w_wait_out;
          in_start  <= w_wait_in;
        end else begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          failure <= 1'b1;
        end
      end else begin
        r_wd <= r_wd + 1'b1;
      end
    end
  end

endmodule
